// File: rtl/display_scan_scheduler.sv
// ---------------------------------------------------------------------------
// display_scan_scheduler
//
// Purpose:
//   Time-multiplexes NUM_CH 4-bit channel values through a single, external,
//   purely combinational Convertidor_Display instance. The converter maps a
//   value 0-15 to two 7-segment patterns: HEX0 is the units digit and HEX1 is
//   the tens digit. This block scans 2*NUM_CH digit positions, lighting one
//   digit at a time for DWELL clock cycles.
//
//   Channel updates arrive on a valid/ready write port. They are held as a
//   single pending write and only applied at a frame boundary, so a frame is
//   never drawn with a mix of old and new values.
//
// Ports:
//   clk          in   1          system clock, rising edge
//   rst          in   1          synchronous reset, active-high
//   wr_valid     in   1          write request
//   wr_ready     out  1          write accepted when wr_valid & wr_ready
//   wr_idx       in   8          target channel (out-of-range writes dropped)
//   wr_data      in   4          new channel value
//   conv_number  out  4          to converter input `number`
//   conv_hex0    in   7          from converter HEX0 (active-low segments)
//   conv_hex1    in   7          from converter HEX1 (active-low segments)
//   seg          out  7          segment drive, active-low (7'h7F = blank)
//   an           out  2*NUM_CH   digit enable, one-hot, active-high
//   frame_done   out  1          1-cycle pulse at the end of each full scan
//
// Configuration macro:
//   DISPLAY_BLANK_LEADING_EN  when defined, the tens digit is blanked for
//                             values below 10. The tens slot still takes its
//                             full dwell time so the scan rate is unchanged.
// ---------------------------------------------------------------------------
module display_scan_scheduler #(
  parameter int NUM_CH  = 2,
  parameter int DWELL   = 50000,
  parameter int DWELL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [7:0]            wr_idx,
  input  logic [3:0]            wr_data,
  output logic [3:0]            conv_number,
  input  logic [6:0]            conv_hex0,
  input  logic [6:0]            conv_hex1,
  output logic [6:0]            seg,
  output logic [2*NUM_CH-1:0]   an,
  output logic                  frame_done
);

  localparam int                 CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                 AN_W       = 2 * NUM_CH;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [6:0]         SEG_BLANK  = 7'h7F;

  // S_LOAD presents the channel value to the converter with all digits dark,
  // S_CAP latches the converter result, S_LO / S_HI light the units and tens
  // digit of the current channel.
  typedef enum logic [1:0] {
    S_LOAD,
    S_CAP,
    S_LO,
    S_HI
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CH_W-1:0]     ch;
  logic [CH_W-1:0]     ch_next;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [DWELL_W-1:0]  dwell_next;

  logic [3:0]          vals [NUM_CH];
  logic [6:0]          hex0_r;
  logic [6:0]          hex1_r;
  logic [6:0]          cap_hex1;

  logic                pending;
  logic [CH_W-1:0]     pend_idx;
  logic [3:0]          pend_data;

  logic [3:0]          conv_next;
  logic [6:0]          seg_next;
  logic [AN_W-1:0]     an_next;
  logic                frame_next;

  logic                wr_fire;
  logic                wr_in_range;
  logic                dwell_last;
  logic                frame_end;

  // Only one write can be outstanding; the port stalls until the pending
  // value has been applied at a frame boundary.
  assign wr_ready    = !pending && !rst;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = int'(wr_idx) < NUM_CH;

  assign dwell_last  = (dwell_cnt == DWELL_LAST);
  assign frame_end   = (state == S_HI) && dwell_last && (ch == CH_LAST);

  // Tens-digit pattern that will be latched in S_CAP.
`ifdef DISPLAY_BLANK_LEADING_EN
  assign cap_hex1 = (conv_number < 4'd10) ? SEG_BLANK : conv_hex1;
`else
  assign cap_hex1 = conv_hex1;
`endif

  // Next-state logic. The output registers are loaded from a function of the
  // state being entered, so an/seg always line up with the state register and
  // never glitch. The dwell counter restarts on every state change.
  always_comb begin
    state_next = state;
    ch_next    = ch;
    dwell_next = dwell_cnt + DWELL_W'(1);
    conv_next  = conv_number;
    frame_next = 1'b0;
    an_next    = '0;
    seg_next   = SEG_BLANK;

    case (state)
      S_LOAD: begin
        conv_next  = vals[ch];
        state_next = S_CAP;
      end
      S_CAP: begin
        state_next = S_LO;
      end
      S_LO: begin
        if (dwell_last) begin
          state_next = S_HI;
        end
      end
      S_HI: begin
        if (dwell_last) begin
          state_next = S_LOAD;
          if (ch == CH_LAST) begin
            ch_next    = '0;
            frame_next = 1'b1;
          end else begin
            ch_next = ch + CH_W'(1);
          end
        end
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase

    if (state_next != state) begin
      dwell_next = '0;
    end

    // On the S_CAP -> S_LO edge hex0_r is being written at the same edge, so
    // the units pattern is taken straight from the converter instead.
    case (state_next)
      S_LO: begin
        an_next  = AN_W'(1) << {ch_next, 1'b0};
        seg_next = (state == S_CAP) ? conv_hex0 : hex0_r;
      end
      S_HI: begin
        an_next  = AN_W'(2) << {ch_next, 1'b0};
        seg_next = hex1_r;
      end
      default: begin
        an_next  = '0;
        seg_next = SEG_BLANK;
      end
    endcase
  end

  // State, scan position and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      ch          <= '0;
      dwell_cnt   <= '0;
      conv_number <= '0;
      an          <= '0;
      seg         <= SEG_BLANK;
      frame_done  <= 1'b0;
      hex0_r      <= SEG_BLANK;
      hex1_r      <= SEG_BLANK;
    end else begin
      state       <= state_next;
      ch          <= ch_next;
      dwell_cnt   <= dwell_next;
      conv_number <= conv_next;
      an          <= an_next;
      seg         <= seg_next;
      frame_done  <= frame_next;
      if (state == S_CAP) begin
        hex0_r <= conv_hex0;
        hex1_r <= cap_hex1;
      end
    end
  end

  // Channel values and the single-entry write buffer. A write accepted in the
  // same cycle as a frame boundary cannot collide with an apply, because a
  // write is only accepted while nothing is pending; it simply waits for the
  // next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      pend_idx  <= '0;
      pend_data <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        vals[i] <= '0;
      end
    end else begin
      if (frame_end && pending) begin
        vals[pend_idx] <= pend_data;
        pending        <= 1'b0;
      end
      if (wr_fire && wr_in_range) begin
        pend_idx  <= wr_idx[CH_W-1:0];
        pend_data <= wr_data;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_display_scan_scheduler
//
// Purpose:
//   Drives display_scan_scheduler with NUM_CH=2, DWELL=4 and a behavioural
//   Convertidor_Display attached. A frame-position model predicts every
//   output on every cycle; directed sequences add literal expectations for
//   the scan pattern, write buffering, reset and leading-digit behaviour.
// ---------------------------------------------------------------------------
module tb_display_scan_scheduler;

  localparam int NUM_CH  = 2;
  localparam int DWELL   = 4;
  localparam int DWELL_W = 16;
  localparam int AN_W    = 2 * NUM_CH;
  localparam int SLOT    = 2 + 2 * DWELL;
  localparam int PERIOD  = NUM_CH * SLOT;

  logic            clk;
  logic            rst;
  logic            wr_valid;
  logic            wr_ready;
  logic [7:0]      wr_idx;
  logic [3:0]      wr_data;
  logic [3:0]      conv_number;
  logic [6:0]      conv_hex0;
  logic [6:0]      conv_hex1;
  logic [6:0]      seg;
  logic [AN_W-1:0] an;
  logic            frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  display_scan_scheduler #(
    .NUM_CH  (NUM_CH),
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .conv_number (conv_number),
    .conv_hex0   (conv_hex0),
    .conv_hex1   (conv_hex1),
    .seg         (seg),
    .an          (an),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low 7-segment patterns for decimal digits.
  function automatic logic [6:0] seg7(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected tens-digit pattern shown by the scheduler for a value.
  function automatic logic [6:0] tensShown(input int v);
`ifdef DISPLAY_BLANK_LEADING_EN
    if (v < 10) return 7'h7F;
`endif
    return seg7(v / 10);
  endfunction

  // Behavioural Convertidor_Display: units on HEX0, tens on HEX1.
  always_comb begin
    conv_hex0 = seg7(int'(conv_number) % 10);
    conv_hex1 = seg7(int'(conv_number) / 10);
  end

  // Model state: cycles since the last reset edge, committed values, the
  // single pending write and the value currently held at the converter.
  int         m_k;
  logic [3:0] m_vals [NUM_CH];
  logic       m_pend;
  int         m_pidx;
  logic [3:0] m_pdata;
  logic [3:0] m_conv;
  bit         model_on = 1'b0;

  // Advance the model by one clock edge using the frame-position arithmetic:
  // each channel owns SLOT cycles (load, capture, DWELL units, DWELL tens).
  task automatic modelStep();
    int  pos;
    bit  acc;
    if (rst) begin
      m_k    = 0;
      m_pend = 1'b0;
      m_conv = 4'd0;
      for (int i = 0; i < NUM_CH; i++) m_vals[i] = 4'd0;
      model_on = 1'b1;
    end else if (model_on) begin
      pos = m_k % PERIOD;
      acc = wr_valid && !m_pend;
      if (pos % SLOT == 0) m_conv = m_vals[pos / SLOT];
      if (pos == PERIOD - 1 && m_pend) begin
        m_vals[m_pidx] = m_pdata;
        m_pend = 1'b0;
      end
      if (acc && int'(wr_idx) < NUM_CH) begin
        m_pend  = 1'b1;
        m_pidx  = int'(wr_idx);
        m_pdata = wr_data;
      end
      m_k++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Generic comparator: every comparison in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  task automatic compareModel();
    int              pos;
    int              slot;
    int              c;
    logic [AN_W-1:0] exp_an;
    logic [6:0]      exp_seg;
    pos  = m_k % PERIOD;
    slot = pos % SLOT;
    c    = pos / SLOT;
    exp_seg = 7'h7F;
    if (slot < 2) begin
      exp_an = '0;
    end else if (slot < 2 + DWELL) begin
      exp_an  = AN_W'(1) << (2 * c);
      exp_seg = seg7(int'(m_conv) % 10);
    end else begin
      exp_an  = AN_W'(1) << (2 * c + 1);
      exp_seg = tensShown(int'(m_conv));
    end
    checkOutput("model_an", 32'(an), 32'(exp_an));
    checkOutput("model_conv_number", 32'(conv_number), 32'(m_conv));
    checkOutput("model_frame_done", 32'(frame_done), 32'(pos == 0 && m_k != 0));
    checkOutput("model_wr_ready", 32'(wr_ready), 32'(!m_pend && !rst));
    if (exp_an != '0) checkOutput("model_seg", 32'(seg), 32'(exp_seg));
  endtask

  initial forever begin
    @(negedge clk);
    if (model_on) compareModel();
  end

  // Drive the write port for exactly one clock edge, just after posedge.
  task automatic applyStimulus(input logic v, input logic [7:0] idx, input logic [3:0] d);
    @(posedge clk);
    #1;
    wr_valid = v;
    wr_idx   = idx;
    wr_data  = d;
  endtask

  // Wait (at negedges) until an equals target, within a cycle budget.
  task automatic waitAn(input logic [AN_W-1:0] target, input string name);
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (an == target) return;
    end
    checkOutput({name, "_timeout"}, 32'(an), 32'(target));
  endtask

  task automatic waitFrame(input string name);
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    checkOutput({name, "_timeout"}, 32'(frame_done), 32'd1);
  endtask

  logic [AN_W-1:0] an_tbl [PERIOD] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2,
                                       4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired: got no finish expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_idx   = 8'd0;
    wr_data  = 4'd0;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_an", 32'(an), 32'h0);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_conv", 32'(conv_number), 32'h0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'h0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Free-run scan pattern over one frame, then the frame_done pulse.
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("release_wr_ready", 32'(wr_ready), 32'h1);
      checkOutput("scan_an", 32'(an), 32'(an_tbl[i]));
      checkOutput("scan_frame_done_low", 32'(frame_done), 32'h0);
    end
    @(negedge clk);
    checkOutput("scan_frame_done_pulse", 32'(frame_done), 32'h1);

    // Mid-frame write of 12 to channel 0.
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 8'd0, 4'hC);
    applyStimulus(1'b0, 8'd0, 4'h0);
    @(negedge clk);
    checkOutput("wr_pending_ready", 32'(wr_ready), 32'h0);
    waitFrame("apply_frame");
    checkOutput("apply_ready_back", 32'(wr_ready), 32'h1);
    @(negedge clk);
    checkOutput("apply_conv_C", 32'(conv_number), 32'hC);
    waitAn(4'h1, "apply_lo");
    checkOutput("apply_units_2", 32'(seg), 32'h24);
    waitAn(4'h2, "apply_hi");
    checkOutput("apply_tens_1", 32'(seg), 32'h79);

    // Out-of-range write: accepted and dropped.
    applyStimulus(1'b1, 8'd3, 4'h5);
    applyStimulus(1'b0, 8'd0, 4'h0);
    @(negedge clk);
    checkOutput("oor_ready", 32'(wr_ready), 32'h1);
    for (int f = 0; f < 2; f++) begin
      waitFrame("oor_frame");
      @(negedge clk);
      checkOutput("oor_ch0_kept", 32'(conv_number), 32'hC);
      waitAn(4'h4, "oor_ch1");
      checkOutput("oor_ch1_kept", 32'(conv_number), 32'h0);
    end

    // Reset during S_HI with a write pending.
    applyStimulus(1'b1, 8'd1, 4'h9);
    applyStimulus(1'b0, 8'd0, 4'h0);
    waitAn(4'h8, "rstmid_hi");
    checkOutput("rstmid_pending", 32'(wr_ready), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_an", 32'(an), 32'h0);
    checkOutput("rstmid_seg", 32'(seg), 32'h7F);
    checkOutput("rstmid_ready", 32'(wr_ready), 32'h1);
    for (int f = 0; f < 2; f++) begin
      waitAn(4'h1, "rstmid_ch0");
      checkOutput("rstmid_ch0_zero", 32'(conv_number), 32'h0);
      waitAn(4'h4, "rstmid_ch1");
      checkOutput("rstmid_ch1_not9", 32'(conv_number), 32'h0);
    end

    // Channel 1 = 5: units '5', tens either blank or '0'.
    applyStimulus(1'b1, 8'd1, 4'h5);
    applyStimulus(1'b0, 8'd0, 4'h0);
    waitFrame("five_frame");
    waitAn(4'h4, "five_lo");
    checkOutput("five_units", 32'(seg), 32'h12);
    waitAn(4'h8, "five_hi");
`ifdef DISPLAY_BLANK_LEADING_EN
    checkOutput("five_tens_blank", 32'(seg), 32'h7F);
`else
    checkOutput("five_tens_zero", 32'(seg), 32'h40);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
